// File: rtl/z80_uart_bus_seq.sv
// z80_uart_bus_seq: sequences Z80 I/O cycles to the on-board 16550 UART.
// Synchronises the Z80 strobes, holds the CPU with WAIT and generates
// CS/RD/WR with set-up, strobe and hold timing, then returns read data.
// Ports:
//   clk, reset                 CPLD clock, synchronous active-high reset
//   iorq_n, m1_n, rd_n, wr_n   Z80 control pins (asynchronous to clk)
//   A, a_hi, cpu_d_in          Z80 address A[7:0], A[10:8], write data
//   cpu_d_out, cpu_d_oe        read data and output enable to the Z80
//   wait_n                     Z80 WAIT (combinational from raw decode)
//   uart_cs_n/rd_n/wr_n/a      16550 chip select, strobes, register address
//   uart_d_in/d_out/d_oe       16550 data bus
module z80_uart_bus_seq #(
    parameter logic [7:0]  PORT_ADDR  = 8'hEF,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 3,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iorq_n,
    input  logic       m1_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [7:0] A,
    input  logic [2:0] a_hi,
    input  logic [7:0] cpu_d_in,
    output logic [7:0] cpu_d_out,
    output logic       cpu_d_oe,
    output logic       wait_n,
    output logic       uart_cs_n,
    output logic       uart_rd_n,
    output logic       uart_wr_n,
    output logic [2:0] uart_a,
    input  logic [7:0] uart_d_in,
    output logic [7:0] uart_d_out,
    output logic       uart_d_oe
);

    localparam int unsigned MAX_CYC =
        (SETUP_CYC > STROBE_CYC) ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                                 : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    localparam int unsigned CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic             iorq_m, iorq_s, rd_m, rd_s, wr_m, wr_s;
    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             start_c, busy_c, dec_c;
    logic             armed, dir_rd;
    logic [7:0]       rd_latch, wr_latch;

    // Two-flop synchronisers; left unreset so a held-low IORQ across reset
    // never looks like a fresh cycle.
    always_ff @(posedge clk) begin
        iorq_m <= iorq_n;
        iorq_s <= iorq_m;
        rd_m   <= rd_n;
        rd_s   <= rd_m;
        wr_m   <= wr_n;
        wr_s   <= wr_m;
    end

    // Next-state and phase counter.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        start_c   = 1'b0;
        case (state)
            S_IDLE: begin
                if (armed && !iorq_s && m1_n && (A == PORT_ADDR) && (!rd_s || !wr_s)) begin
                    start_c   = 1'b1;
                    state_nxt = S_SETUP;
                    cnt_nxt   = SETUP_LD;
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    state_nxt = S_STROBE;
                    cnt_nxt   = STROBE_LD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_STROBE: begin
                if (cnt == '0) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = HOLD_LD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_DONE: begin
                if (iorq_s) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy_c = (state == S_SETUP) || (state == S_STROBE) || (state == S_HOLD);

    // State, access latches and registered UART-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            armed     <= 1'b0;
            dir_rd    <= 1'b0;
            uart_a    <= 3'd0;
            wr_latch  <= 8'd0;
            rd_latch  <= 8'd0;
            uart_cs_n <= 1'b1;
            uart_rd_n <= 1'b1;
            uart_wr_n <= 1'b1;
            uart_d_oe <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (start_c) begin
                armed    <= 1'b0;
                dir_rd   <= !rd_s;
                uart_a   <= a_hi;
                wr_latch <= cpu_d_in;
            end else if (iorq_s) begin
                armed <= 1'b1;
            end
            // Capture on the last strobe edge while RD is still low at the UART.
            if ((state == S_STROBE) && (cnt == '0) && dir_rd) begin
                rd_latch <= uart_d_in;
            end
            uart_cs_n <= !busy_c;
            uart_rd_n <= !((state == S_STROBE) && dir_rd);
            uart_wr_n <= !((state == S_STROBE) && !dir_rd);
            uart_d_oe <= busy_c && !dir_rd;
        end
    end

    assign uart_d_out = wr_latch;
    assign cpu_d_out  = rd_latch;

    // WAIT and read-data enable use the raw pins so they follow the CPU
    // without synchroniser delay.
    assign dec_c    = !iorq_n && m1_n && (A == PORT_ADDR);
    assign wait_n   = reset || !(dec_c && (busy_c || ((state == S_IDLE) && armed)));
    assign cpu_d_oe = !reset && (state == S_DONE) && dir_rd && !iorq_n && !rd_n;

endmodule

// File: tb/tb_z80_uart_bus_seq.sv
// Bench for z80_uart_bus_seq: timeline-based model of the access sequence,
// directed scenarios with literal timing expectations, then random cycles.
module tb_z80_uart_bus_seq;

    localparam logic [7:0]  PORT     = 8'hEF;
    localparam int unsigned T_SETUP  = 1;
    localparam int unsigned T_STROBE = 3;
    localparam int unsigned T_HOLD   = 1;
    localparam int unsigned T_SUM    = T_SETUP + T_STROBE + T_HOLD;

    logic       clk;
    logic       reset;
    logic       iorq_n, m1_n, rd_n, wr_n;
    logic [7:0] A;
    logic [2:0] a_hi;
    logic [7:0] cpu_d_in, uart_d_in;
    logic [7:0] cpu_d_out, uart_d_out;
    logic       cpu_d_oe, wait_n, uart_cs_n, uart_rd_n, uart_wr_n, uart_d_oe;
    logic [2:0] uart_a;
    logic [7:0] sw_cpu_d_out, sw_uart_d_out;
    logic       sw_cpu_d_oe, sw_wait_n, sw_cs_n, sw_rd_n, sw_wr_n, sw_d_oe;
    logic [2:0] sw_uart_a;

    int checks   = 0;
    int failures = 0;

    z80_uart_bus_seq u_dut (
        .clk(clk), .reset(reset), .iorq_n(iorq_n), .m1_n(m1_n), .rd_n(rd_n), .wr_n(wr_n),
        .A(A), .a_hi(a_hi), .cpu_d_in(cpu_d_in), .cpu_d_out(cpu_d_out), .cpu_d_oe(cpu_d_oe),
        .wait_n(wait_n), .uart_cs_n(uart_cs_n), .uart_rd_n(uart_rd_n), .uart_wr_n(uart_wr_n),
        .uart_a(uart_a), .uart_d_in(uart_d_in), .uart_d_out(uart_d_out), .uart_d_oe(uart_d_oe)
    );

    z80_uart_bus_seq #(.PORT_ADDR(8'hEF), .SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(3)) u_sweep (
        .clk(clk), .reset(reset), .iorq_n(iorq_n), .m1_n(m1_n), .rd_n(rd_n), .wr_n(wr_n),
        .A(A), .a_hi(a_hi), .cpu_d_in(cpu_d_in), .cpu_d_out(sw_cpu_d_out), .cpu_d_oe(sw_cpu_d_oe),
        .wait_n(sw_wait_n), .uart_cs_n(sw_cs_n), .uart_rd_n(sw_rd_n), .uart_wr_n(sw_wr_n),
        .uart_a(sw_uart_a), .uart_d_in(uart_d_in), .uart_d_out(sw_uart_d_out), .uart_d_oe(sw_d_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_BUSY, M_DONE} mmode_t;
    mmode_t     m_mode  = M_IDLE;
    int         m_el    = 0;      // clk cycles elapsed since the access started
    logic       m_armed = 1'b0;
    logic       m_dir_rd = 1'b0;
    logic [1:0] h_iorq = 2'b11, h_rd = 2'b11, h_wr = 2'b11;
    logic       e_cs = 1'b1, e_rd = 1'b1, e_wr = 1'b1, e_doe = 1'b0;
    logic [2:0] e_a = 3'd0;
    logic [7:0] e_wl = 8'd0, e_rl = 8'd0;
    logic       model_ok = 1'b0;
    logic       is_v, rs_v, ws_v, st_v, bz_v;

    always @(posedge clk) begin
        // Pin values seen two edges ago are what the synchronised view holds now.
        is_v   = h_iorq[1];
        rs_v   = h_rd[1];
        ws_v   = h_wr[1];
        h_iorq = {h_iorq[0], iorq_n};
        h_rd   = {h_rd[0], rd_n};
        h_wr   = {h_wr[0], wr_n};
        if (reset) begin
            m_mode = M_IDLE; m_el = 0; m_armed = 1'b0; m_dir_rd = 1'b0;
            e_cs = 1'b1; e_rd = 1'b1; e_wr = 1'b1; e_doe = 1'b0;
            e_a = 3'd0; e_wl = 8'd0; e_rl = 8'd0;
        end else begin
            bz_v  = (m_mode == M_BUSY);
            st_v  = bz_v && (m_el >= int'(T_SETUP)) && (m_el < int'(T_SETUP + T_STROBE));
            e_cs  = !bz_v;
            e_rd  = !(st_v && m_dir_rd);
            e_wr  = !(st_v && !m_dir_rd);
            e_doe = bz_v && !m_dir_rd;
            case (m_mode)
                M_IDLE: begin
                    if (m_armed && !is_v && m1_n && (A == PORT) && (!rs_v || !ws_v)) begin
                        m_mode = M_BUSY; m_el = 0; m_armed = 1'b0;
                        m_dir_rd = !rs_v; e_a = a_hi; e_wl = cpu_d_in;
                    end else if (is_v) m_armed = 1'b1;
                end
                M_BUSY: begin
                    if (m_dir_rd && (m_el == int'(T_SETUP + T_STROBE) - 1)) e_rl = uart_d_in;
                    m_el++;
                    if (m_el == int'(T_SUM)) m_mode = M_DONE;
                    if (is_v) m_armed = 1'b1;
                end
                default: begin
                    if (is_v) begin m_mode = M_IDLE; m_armed = 1'b1; end
                end
            endcase
        end
        model_ok = 1'b1;
    end

    // ---------------- per-cycle compare ----------------
    logic x_dec, x_wait, x_oe;
    always @(posedge clk) begin
        #1;
        if (model_ok) begin
            x_dec  = !iorq_n && m1_n && (A == PORT);
            x_wait = reset ? 1'b1 :
                     !(x_dec && ((m_mode == M_BUSY) || ((m_mode == M_IDLE) && m_armed)));
            x_oe   = !reset && (m_mode == M_DONE) && m_dir_rd && !iorq_n && !rd_n;
            chk("uart_cs_n",  32'(uart_cs_n),  32'(e_cs));
            chk("uart_rd_n",  32'(uart_rd_n),  32'(e_rd));
            chk("uart_wr_n",  32'(uart_wr_n),  32'(e_wr));
            chk("uart_d_oe",  32'(uart_d_oe),  32'(e_doe));
            chk("uart_a",     32'(uart_a),     32'(e_a));
            chk("uart_d_out", 32'(uart_d_out), 32'(e_wl));
            chk("cpu_d_out",  32'(cpu_d_out),  32'(e_rl));
            chk("cpu_d_oe",   32'(cpu_d_oe),   32'(x_oe));
            chk("wait_n",     32'(wait_n),     32'(x_wait));
        end
    end

    // Data seen on uart_d_out at every falling CS edge.
    logic       prev_cs = 1'b1;
    logic [7:0] pulse_q[$];
    always @(posedge clk) begin
        #1;
        if (prev_cs && !uart_cs_n) pulse_q.push_back(uart_d_out);
        prev_cs = uart_cs_n;
    end

    logic rand_udin = 1'b0;
    always @(negedge clk) if (rand_udin) uart_d_in = 8'($urandom);

    // ---------------- helpers ----------------
    function automatic int first_zero(input logic [16:0] v);
        for (int i = 0; i < 17; i++) if (v[i] == 1'b0) return i;
        return -1;
    endfunction

    function automatic int count_zero(input logic [16:0] v);
        int n = 0;
        for (int i = 0; i < 17; i++) if (v[i] == 1'b0) n++;
        return n;
    endfunction

    function automatic int rise_at(input logic [16:0] v);
        for (int i = 1; i < 17; i++) if (v[i] && !v[i-1]) return i;
        return -1;
    endfunction

    task automatic release_bus(input int gap);
        @(negedge clk);
        iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; A = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic io_cycle(input logic [7:0] addr, input logic m1, input logic is_rd,
                            input logic [7:0] data, input logic [2:0] hi,
                            input int early, input int gap);
        int n;
        @(negedge clk);
        A = addr; a_hi = hi; cpu_d_in = data; m1_n = m1; iorq_n = 1'b0;
        rd_n = !(m1 && is_rd); wr_n = !(m1 && !is_rd);
        if (early > 0) begin
            repeat (early) @(negedge clk);
        end else if (!m1 || addr != PORT) begin
            repeat (4) @(negedge clk);
        end else begin
            n = 0;
            do begin @(negedge clk); n++; end while (wait_n !== 1'b1 && n < 40);
            if (wait_n !== 1'b1) chk("wait_timeout", 32'(wait_n), 32'd1);
            @(negedge clk);
        end
        iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; A = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    logic [16:0] r_cs, r_st, r_wt, s_cs, s_st, s_wt;
    logic [2:0]  at_a;
    logic [7:0]  at_d;
    logic        at_oe;

    // Start a matching access and record both DUTs for 16 edges; bus left asserted.
    task automatic rec_access(input logic is_rd, input logic [7:0] data, input logic [2:0] hi);
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        A = PORT; a_hi = hi; cpu_d_in = data; m1_n = 1'b1; iorq_n = 1'b0;
        rd_n = !is_rd; wr_n = is_rd;
        #1;
        r_cs[0] = uart_cs_n; r_st[0] = 1'b1; r_wt[0] = wait_n;
        s_cs[0] = sw_cs_n;   s_st[0] = 1'b1; s_wt[0] = sw_wait_n;
        for (int i = 1; i < 17; i++) begin
            @(posedge clk); #1;
            r_cs[i] = uart_cs_n; r_st[i] = is_rd ? uart_rd_n : uart_wr_n; r_wt[i] = wait_n;
            s_cs[i] = sw_cs_n;   s_st[i] = is_rd ? sw_rd_n : sw_wr_n;     s_wt[i] = sw_wait_n;
            if (!uart_cs_n && !seen) begin
                seen = 1'b1; at_a = uart_a; at_d = uart_d_out; at_oe = uart_d_oe;
            end
        end
    endtask

    task automatic ignored_cycle(input logic [7:0] addr, input logic m1, input string tag);
        @(negedge clk);
        A = addr; a_hi = 3'd1; m1_n = m1; iorq_n = 1'b0;
        rd_n = !m1; wr_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk({tag, "_cs_n"}, 32'(uart_cs_n), 32'd1);
            chk({tag, "_rd_n"}, 32'(uart_rd_n), 32'd1);
            chk({tag, "_wait_n"}, 32'(wait_n), 32'd1);
        end
        release_bus(3);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; iorq_n = 1'b1; m1_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        A = 8'h00; a_hi = 3'd0; cpu_d_in = 8'h00; uart_d_in = 8'h00;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(uart_cs_n), 32'd1);
        chk("rst_wait_n", 32'(wait_n), 32'd1);
        chk("rst_d_oe", 32'(uart_d_oe), 32'd0);
        chk("rst_cpu_oe", 32'(cpu_d_oe), 32'd0);

        // Directed write: start edge is the 3rd after IORQ falls.
        rec_access(1'b0, 8'h5A, 3'd3);
        chk("wr_wait_low", 32'(r_wt[0]), 32'd0);
        chk("wr_cs_first", 32'(first_zero(r_cs)), 32'd4);
        chk("wr_cs_len", 32'(count_zero(r_cs)), 32'd5);
        chk("wr_strobe_first", 32'(first_zero(r_st)), 32'd5);
        chk("wr_strobe_len", 32'(count_zero(r_st)), 32'd3);
        chk("wr_wait_rise", 32'(rise_at(r_wt)), 32'd8);
        chk("wr_uart_a", 32'(at_a), 32'd3);
        chk("wr_uart_d", 32'(at_d), 32'h5A);
        chk("wr_uart_oe", 32'(at_oe), 32'd1);
        chk("sw_cs_len", 32'(count_zero(s_cs)), 32'd6);
        chk("sw_strobe_ofs", 32'(first_zero(s_st) - first_zero(s_cs)), 32'd2);
        chk("sw_strobe_len", 32'(count_zero(s_st)), 32'd1);
        chk("sw_wait_rise", 32'(rise_at(s_wt)), 32'd9);
        release_bus(3);

        // Directed read returning 0xC3.
        uart_d_in = 8'hC3;
        rec_access(1'b1, 8'h00, 3'd5);
        chk("rd_strobe_len", 32'(count_zero(r_st)), 32'd3);
        chk("rd_wait_rise", 32'(rise_at(r_wt)), 32'd8);
        chk("rd_uart_a", 32'(at_a), 32'd5);
        chk("rd_cpu_oe", 32'(cpu_d_oe), 32'd1);
        chk("rd_cpu_d", 32'(cpu_d_out), 32'hC3);
        chk("sw_rd_cpu_d", 32'(sw_cpu_d_out), 32'hC3);
        @(negedge clk); rd_n = 1'b1; #1;
        chk("rd_oe_release", 32'(cpu_d_oe), 32'd0);
        release_bus(3);

        ignored_cycle(8'hEE, 1'b1, "nomatch");
        ignored_cycle(PORT, 1'b0, "inta");

        // Reset in the middle of a write strobe.
        @(negedge clk);
        A = PORT; a_hi = 3'd2; cpu_d_in = 8'h77; m1_n = 1'b1; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("mid_strobe_wr_n", 32'(uart_wr_n), 32'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_cs_n", 32'(uart_cs_n), 32'd1);
        chk("rst_mid_wr_n", 32'(uart_wr_n), 32'd1);
        chk("rst_mid_d_oe", 32'(uart_d_oe), 32'd0);
        chk("rst_mid_wait_n", 32'(wait_n), 32'd1);
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("post_rst_cs_n", 32'(uart_cs_n), 32'd1);
            chk("post_rst_wait_n", 32'(wait_n), 32'd1);
        end
        release_bus(3);
        io_cycle(PORT, 1'b1, 1'b0, 8'h3C, 3'd4, 0, 3);
        chk("post_rst_uart_d", 32'(uart_d_out), 32'h3C);
        chk("post_rst_uart_a", 32'(uart_a), 32'd4);

        // Back-to-back writes with two idle clocks between them.
        pulse_q.delete();
        io_cycle(PORT, 1'b1, 1'b0, 8'h11, 3'd0, 0, 2);
        io_cycle(PORT, 1'b1, 1'b0, 8'h22, 3'd1, 0, 4);
        chk("b2b_pulses", 32'(pulse_q.size()), 32'd2);
        if (pulse_q.size() == 2) begin
            chk("b2b_data0", 32'(pulse_q[0]), 32'h11);
            chk("b2b_data1", 32'(pulse_q[1]), 32'h22);
        end

        // Random cycles, including mismatches, INTA and early IORQ release.
        rand_udin = 1'b1;
        for (int k = 0; k < 150; k++) begin
            logic [7:0] addr;
            int early;
            addr  = ($urandom_range(0, 5) == 0) ? 8'($urandom) : PORT;
            early = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
            io_cycle(addr, ($urandom_range(0, 9) != 0), 1'($urandom), 8'($urandom),
                     3'($urandom), early, int'($urandom_range(2, 4)));
        end
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, failures=%0d", failures);
        $fatal(1);
    end

endmodule
